ls_backtrack_ctrl: RTL and testbench
====================================

Name: ls_backtrack_ctrl

Overview:
Armijo backtracking line-search controller. It sits directly downstream of the line-search compare stage and consumes that stage's `result_compare` bit. Each iteration it drives the trial step `alphai` to the function evaluator and to the compare stage, waits for `phi(alphai)` and the compare latency, then either accepts `alphai` or shrinks it by `tau` and retries. It reports the accepted step, or failure after `MAX_ITER` trials, to the outer optimiser.

Parameters:
- DATA_WIDTH, 32, IEEE-754 single-precision word width.
- MAX_ITER, 16, maximum trial steps per search (≥1).
- CMP_LAT, 1, clock edges from `eval_valid` until `result_compare` is valid.
- ITER_W, $clog2(MAX_ITER+1), iteration counter width.

Ports:
- aclk  in  1  clock; all logic on posedge.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a search; ignored while busy.
- alpha_init  in  DATA_WIDTH  initial step, sampled on accepted start.
- tau  in  DATA_WIDTH  shrink factor, sampled on accepted start; caller guarantees 0<tau<1.
- eval_req  out  1  high while waiting for phi(alphai) from the evaluator.
- eval_valid  in  1  evaluator has phi(alphai) on the compare stage input; honoured only in EVAL.
- alphai  out  DATA_WIDTH  current trial step, fed to evaluator and compare stage; stable from entry to EVAL until leaving DECIDE.
- result_compare  in  1  compare stage verdict (1 = sufficient decrease satisfied).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at search end.
- success  out  1  1 = a step was accepted; held until next accepted start.
- alpha_out  out  DATA_WIDTH  accepted or last-tried step; held until next accepted start.
- iter_count  out  ITER_W  number of steps evaluated; held until next accepted start.

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE. All outputs 0, including alphai, alpha_out and iter_count.
- States: IDLE, EVAL, WAIT_CMP, DECIDE, SHRINK, DONE.
- IDLE: on start=1, latch alpha_init into alphai and tau into tau_r; iter_count←1; success←0; → EVAL.
- EVAL: eval_req=1. On eval_valid=1: eval_req drops next cycle; cnt←CMP_LAT-1; → WAIT_CMP.
- WAIT_CMP: decrement cnt; at cnt==0 → DECIDE. Evaluator holds phi stable from eval_valid until the next eval_req.
- DECIDE: sample result_compare.
  - 1 → success←1, alpha_out←alphai, → DONE.
  - 0 and iter_count==MAX_ITER → success←0, alpha_out←alphai, → DONE.
  - Otherwise → SHRINK.
- SHRINK: alphai←alphai×tau_r via combinational float_mul. If the product exponent field is 0 (zero/flushed denormal): success←0, alpha_out←product, → DONE. Otherwise iter_count←iter_count+1, → EVAL.
- DONE: done=1 for exactly one cycle; → IDLE.
- Latency per iteration: EVAL→(eval_valid edge)→CMP_LAT edges→DECIDE→SHRINK. With eval_valid in the first EVAL cycle and CMP_LAT=1: start edge to done pulse = 4 cycles for an iteration-1 accept; each reject adds 4.
- start while busy: ignored; no latch changes.
- eval_valid outside EVAL: ignored.
- result_compare outside DECIDE: ignored.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- Float handling: no NaN/Inf checks. Bit patterns pass through untouched except via the multiply.

Decomposition:
- Package ls_pkg: typedef `float_t` (logic [31:0]), enum `ls_state_e` (6 states), constants FLOAT_ONE=32'h3F800000 and FLOAT_HALF=32'h3F000000 for benches.
- One sub-module: the existing float_mul IP instance (`u_alpha_shrink`). No other hierarchy.

Test Plan:
1. alpha_init=3F800000, tau=3F000000, result_compare=1 on first DECIDE → done 4 cycles after start; success=1, alpha_out=3F800000, iter_count=1.
2. Same inputs, result_compare 0,0,1 → alphai sequence 3F800000, 3F000000, 3E800000; success=1, alpha_out=3E800000, iter_count=3.
3. MAX_ITER=4, result_compare always 0 → success=0, alpha_out=3E000000, iter_count=4, exactly one done pulse.
4. alpha_init=00800000, tau=3F000000, result_compare=0 → SHRINK yields zero exponent; success=0, iter_count=1, done pulse.
5. Assert areset during WAIT_CMP → busy, eval_req, alphai, iter_count =0 the same cycle; no done; a fresh start afterwards behaves as scenario 1.
6. Pulse start again during EVAL with alpha_init=40000000 → ignored; alphai stays 3F800000; search completes per scenario 1.

Source files
------------

// File: rtl/ls_backtrack_ctrl_pkg.sv
// Shared types and constants for the Armijo backtracking line-search controller.
package ls_pkg;

    typedef logic [31:0] float_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EVAL     = 3'd1,
        S_WAIT_CMP = 3'd2,
        S_DECIDE   = 3'd3,
        S_SHRINK   = 3'd4,
        S_DONE     = 3'd5
    } ls_state_e;

    localparam float_t FLOAT_ONE  = 32'h3F80_0000;
    localparam float_t FLOAT_HALF = 32'h3F00_0000;

    // Zero or flushed-denormal result: biased exponent field is all zeros.
    function automatic logic exp_is_zero(input float_t f);
        return (f[30:23] == 8'd0);
    endfunction

endpackage

// File: rtl/ls_backtrack_ctrl_if.sv
// Handshake bundle between the line-search controller, the evaluator/compare stage and the optimiser.
interface ls_backtrack_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ITER_W     = 5
);
    logic                  start;
    logic [DATA_WIDTH-1:0] alpha_init;
    logic [DATA_WIDTH-1:0] tau;
    logic                  eval_req;
    logic                  eval_valid;
    logic [DATA_WIDTH-1:0] alphai;
    logic                  result_compare;
    logic                  busy;
    logic                  done;
    logic                  success;
    logic [DATA_WIDTH-1:0] alpha_out;
    logic [ITER_W-1:0]     iter_count;

    modport master (
        output start, alpha_init, tau, eval_valid, result_compare,
        input  eval_req, alphai, busy, done, success, alpha_out, iter_count
    );

    modport slave (
        input  start, alpha_init, tau, eval_valid, result_compare,
        output eval_req, alphai, busy, done, success, alpha_out, iter_count
    );
endinterface

// File: rtl/ls_backtrack_ctrl_float_mul.sv
// Combinational single-precision multiply: round-to-nearest-even, zero/denormal inputs and
// underflowing results flush to signed zero, overflow saturates to infinity, no NaN handling.
module float_mul
    import ls_pkg::*;
(
    input  float_t i_a,
    input  float_t i_b,
    output float_t o_p
);

    logic               w_sign;
    logic [23:0]        w_ma;
    logic [23:0]        w_mb;
    logic [47:0]        w_prod;
    logic               w_norm;
    logic [23:0]        w_mant;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [24:0]        w_mant_rnd;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_ea;
    logic signed [9:0]  w_eb;
    logic signed [9:0]  w_exp;

    // Mantissa product, normalisation, rounding and exponent range handling.
    always_comb begin
        w_sign = i_a[31] ^ i_b[31];
        w_ma   = {1'b1, i_a[22:0]};
        w_mb   = {1'b1, i_b[22:0]};
        w_prod = {24'd0, w_ma} * {24'd0, w_mb};
        w_norm = w_prod[47];
        if (w_norm) begin
            w_mant   = w_prod[47:24];
            w_guard  = w_prod[23];
            w_sticky = |w_prod[22:0];
        end else begin
            w_mant   = w_prod[46:23];
            w_guard  = w_prod[22];
            w_sticky = |w_prod[21:0];
        end
        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {24'd0, w_round_up};
        // A carry out of rounding leaves 1.000.. so the fraction is the shifted-down zeros.
        w_frac = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
        w_ea   = signed'({2'b00, i_a[30:23]});
        w_eb   = signed'({2'b00, i_b[30:23]});
        w_exp  = w_ea + w_eb - 10'sd127
               + (w_norm ? 10'sd1 : 10'sd0)
               + (w_mant_rnd[24] ? 10'sd1 : 10'sd0);
        if (exp_is_zero(i_a) || exp_is_zero(i_b)) begin
            o_p = {w_sign, 31'd0};
        end else if (w_exp <= 10'sd0) begin
            o_p = {w_sign, 31'd0};
        end else if (w_exp >= 10'sd255) begin
            o_p = {w_sign, 8'hFF, 23'd0};
        end else begin
            o_p = {w_sign, w_exp[7:0], w_frac};
        end
    end

endmodule

// File: rtl/ls_backtrack_ctrl.sv
// Armijo backtracking line-search controller: issues trial steps, waits for the compare
// verdict, accepts or shrinks by tau, and reports the outcome to the optimiser.
module ls_backtrack_ctrl
    import ls_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_ITER   = 16,
    parameter int CMP_LAT    = 1,
    parameter int ITER_W     = $clog2(MAX_ITER + 1)
) (
    input  logic               aclk,
    input  logic               areset,
    ls_backtrack_ctrl_if.slave bus
);

    localparam int                CNT_W    = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CMP_LAT - 1);

    logic                  r_rst_meta;
    logic                  r_rst_sync;
    logic                  w_rst;
    ls_state_e             r_state;
    ls_state_e             w_state_nx;
    logic [DATA_WIDTH-1:0] r_alphai;
    logic [DATA_WIDTH-1:0] r_tau;
    logic [DATA_WIDTH-1:0] r_alpha_out;
    logic [ITER_W-1:0]     r_iter;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_success;
    logic                  r_busy;
    logic                  r_eval_req;
    logic                  r_done;
    logic                  w_busy_nx;
    logic                  w_eval_req_nx;
    logic                  w_done_nx;
    float_t                w_prod;
    logic                  w_prod_zero;

    // Reset asserts immediately and releases two clock edges after areset falls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst = r_rst_sync;

    float_mul u_alpha_shrink (
        .i_a (r_alphai),
        .i_b (r_tau),
        .o_p (w_prod)
    );

    assign w_prod_zero = exp_is_zero(w_prod);

    // FSM state register.
    always_ff @(posedge aclk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nx = S_EVAL;
                else           w_state_nx = S_IDLE;
            end
            S_EVAL: begin
                if (bus.eval_valid) w_state_nx = S_WAIT_CMP;
                else                w_state_nx = S_EVAL;
            end
            S_WAIT_CMP: begin
                if (r_cnt == {CNT_W{1'b0}}) w_state_nx = S_DECIDE;
                else                        w_state_nx = S_WAIT_CMP;
            end
            S_DECIDE: begin
                if (bus.result_compare || (r_iter == ITER_MAX)) w_state_nx = S_DONE;
                else                                            w_state_nx = S_SHRINK;
            end
            S_SHRINK: begin
                if (w_prod_zero) w_state_nx = S_DONE;
                else             w_state_nx = S_EVAL;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status decoded from the upcoming state so the registered flags line up with it.
    always_comb begin
        w_busy_nx     = (w_state_nx != S_IDLE);
        w_eval_req_nx = (w_state_nx == S_EVAL);
        w_done_nx     = (w_state_nx == S_DONE);
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge aclk or posedge w_rst) begin
        if (w_rst) begin
            r_alphai    <= {DATA_WIDTH{1'b0}};
            r_tau       <= {DATA_WIDTH{1'b0}};
            r_alpha_out <= {DATA_WIDTH{1'b0}};
            r_iter      <= {ITER_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_success   <= 1'b0;
            r_busy      <= 1'b0;
            r_eval_req  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy     <= w_busy_nx;
            r_eval_req <= w_eval_req_nx;
            r_done     <= w_done_nx;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_alphai  <= bus.alpha_init;
                        r_tau     <= bus.tau;
                        r_iter    <= ITER_ONE;
                        r_success <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (bus.eval_valid) r_cnt <= CNT_LOAD;
                end
                S_WAIT_CMP: begin
                    if (r_cnt != {CNT_W{1'b0}}) r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
                S_DECIDE: begin
                    if (bus.result_compare) begin
                        r_success   <= 1'b1;
                        r_alpha_out <= r_alphai;
                    end else if (r_iter == ITER_MAX) begin
                        r_success   <= 1'b0;
                        r_alpha_out <= r_alphai;
                    end
                end
                S_SHRINK: begin
                    r_alphai <= w_prod;
                    // An underflowed step cannot make progress; report it as the failed result.
                    if (w_prod_zero) begin
                        r_success   <= 1'b0;
                        r_alpha_out <= w_prod;
                    end else begin
                        r_iter <= r_iter + ITER_ONE;
                    end
                end
                S_DONE: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
                default: begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.eval_req   = r_eval_req;
    assign bus.alphai     = r_alphai;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.success    = r_success;
    assign bus.alpha_out  = r_alpha_out;
    assign bus.iter_count = r_iter;

endmodule

// File: tb/tb_ls_backtrack_ctrl.sv
// Randomised self-checking bench for ls_backtrack_ctrl against a real-arithmetic search model.
module tb_ls_backtrack_ctrl;
    import ls_pkg::*;

    localparam int MAXI = 4;
    localparam int CL   = 1;
    localparam int IW   = $clog2(MAXI + 1);

    logic aclk   = 1'b0;
    logic areset = 1'b0;

    ls_backtrack_ctrl_if #(.DATA_WIDTH(32), .ITER_W(IW)) bus ();

    ls_backtrack_ctrl #(
        .DATA_WIDTH (32),
        .MAX_ITER   (MAXI),
        .CMP_LAT    (CL),
        .ITER_W     (IW)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    int     n_vec = 0;
    int     n_err = 0;
    bit     verd_a [0:MAXI-1];
    int     dly_a  [0:MAXI-1];
    float_t m_trial [0:MAXI];
    logic   m_succ = 1'b0;
    float_t m_out  = 32'd0;
    int     m_iter = 0;
    int     m_lat  = 0;
    bit     m_in_search = 1'b0;
    time    t_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        real v;
        int  e;
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return v;
    endfunction

    // Exact real product, then round-to-nearest-even to 24 significant bits.
    function automatic logic [31:0] m_fmul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        real  p, sc, fl, r;
        int   e, m, be;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = f2r(a) * f2r(b);
        e = 0;
        while (p >= 2.0) begin p = p / 2.0; e++; end
        while (p < 1.0)  begin p = p * 2.0; e--; end
        sc = p * 8388608.0;
        fl = $floor(sc);
        r  = sc - fl;
        m  = $rtoi(fl);
        if (r > 0.5 || (r == 0.5 && m[0])) m = m + 1;
        if (m == 16777216) begin m = 8388608; e++; end
        be = e + 127;
        if (be <= 0)   return {s, 31'd0};
        if (be >= 255) return {s, 8'hFF, 23'd0};
        return {s, be[7:0], m[22:0]};
    endfunction

    // Single compare process: trial steps while evaluating, results at done, held values when idle.
    int   c_idx = 0;
    logic c_prev_req = 1'b0;
    logic c_prev_done = 1'b0;
    always @(negedge aclk) begin
        if (areset) begin
            c_idx = 0;
            c_prev_req = 1'b0;
            c_prev_done = 1'b0;
        end else begin
            if (!bus.busy) c_idx = 0;
            if (bus.eval_req && !c_prev_req && c_idx < MAXI) c_idx++;
            if (bus.eval_req) begin
                chk("alphai", bus.alphai, m_trial[c_idx]);
                chk("iter_in_eval", 32'(bus.iter_count), 32'(c_idx));
            end
            if (bus.done) begin
                if (!m_in_search) chk("spurious_done", 32'(bus.done), 32'd0);
                else begin
                    chk("done_success", 32'(bus.success), 32'(m_succ));
                    chk("done_alpha_out", bus.alpha_out, m_out);
                    chk("done_iter", 32'(bus.iter_count), 32'(m_iter));
                    chk("done_latency", 32'(int'(($time - t_start + 1) / 10)), 32'(m_lat));
                    chk("done_single", 32'(c_prev_done), 32'd0);
                end
            end
            if (!bus.busy) begin
                chk("idle_success", 32'(bus.success), 32'(m_succ));
                chk("idle_alpha_out", bus.alpha_out, m_out);
                chk("idle_iter", 32'(bus.iter_count), 32'(m_iter));
                chk("idle_eval_req", 32'(bus.eval_req), 32'd0);
                chk("idle_done", 32'(bus.done), 32'd0);
            end
            c_prev_req  = bus.eval_req;
            c_prev_done = bus.done;
        end
    end

    task automatic run_search(input float_t a0, input float_t t0, input bit force_noise, input bit abort);
        float_t alpha, p, tr [0:MAXI];
        logic   succ;
        float_t outv;
        int     it, lat, w, iter;
        bit     fin, got, in_eval;
        for (int i = 0; i <= MAXI; i++) tr[i] = 32'd0;
        alpha = a0; it = 1; lat = 1; fin = 1'b0; succ = 1'b0; outv = 32'd0;
        while (!fin) begin
            tr[it] = alpha;
            lat += 1 + dly_a[it-1] + CL + 1;
            if (verd_a[it-1]) begin
                succ = 1'b1; outv = alpha; fin = 1'b1;
            end else if (it == MAXI) begin
                succ = 1'b0; outv = alpha; fin = 1'b1;
            end else begin
                p = m_fmul(alpha, t0);
                lat += 1;
                if (p[30:23] == 8'd0) begin
                    succ = 1'b0; outv = p; fin = 1'b1;
                end else begin
                    alpha = p; it++;
                end
            end
        end
        @(negedge aclk); #1;
        m_trial = tr; m_succ = succ; m_out = outv; m_iter = it; m_lat = lat;
        m_in_search = 1'b1; t_start = $time;
        bus.start = 1'b1; bus.alpha_init = a0; bus.tau = t0;
        got = 1'b0; in_eval = 1'b0; w = 0; iter = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk); #1;
            bus.start = 1'b0;
            bus.eval_valid = 1'b0;
            if (abort && iter == 1 && !bus.eval_req) begin
                chk("pre_rst_busy", 32'(bus.busy), 32'd1);
                areset = 1'b1;
                m_succ = 1'b0; m_out = 32'd0; m_iter = 0; m_in_search = 1'b0;
                #1;
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_eval_req", 32'(bus.eval_req), 32'd0);
                chk("rst_alphai", bus.alphai, 32'd0);
                chk("rst_iter", 32'(bus.iter_count), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
                chk("rst_alpha_out", bus.alpha_out, 32'd0);
                got = 1'b1;
                break;
            end
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.eval_req) begin
                if (!in_eval) begin in_eval = 1'b1; w = 0; end
                if (force_noise || $urandom_range(0, 3) == 0) begin
                    bus.start = 1'b1;
                    bus.alpha_init = force_noise ? 32'h4000_0000 : $urandom;
                    bus.tau = $urandom;
                end
                if (w >= dly_a[(iter < MAXI) ? iter : MAXI-1]) begin
                    bus.eval_valid = 1'b1;
                    bus.result_compare = (iter < MAXI) ? verd_a[iter] : 1'b1;
                    iter++;
                    in_eval = 1'b0;
                end else begin
                    w++;
                    bus.result_compare = 1'($urandom_range(0, 1));
                end
            end else begin
                bus.eval_valid = 1'($urandom_range(0, 1));
            end
        end
        bus.start = 1'b0;
        bus.eval_valid = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL search_timeout: got no done, expected done within 200 cycles");
        end
        m_in_search = 1'b0;
        if (abort) begin
            repeat (2) @(negedge aclk);
            #1 areset = 1'b0;
            repeat (4) @(negedge aclk);
        end
    endtask

    task automatic set_plan(input bit v0, input bit v1, input bit v2, input bit v3);
        verd_a[0] = v0; verd_a[1] = v1; verd_a[2] = v2; verd_a[3] = v3;
        for (int i = 0; i < MAXI; i++) dly_a[i] = 0;
    endtask

    initial begin
        float_t a0, t0;
        bus.start = 1'b0; bus.alpha_init = 32'd0; bus.tau = 32'd0;
        bus.eval_valid = 1'b0; bus.result_compare = 1'b0;
        for (int i = 0; i <= MAXI; i++) m_trial[i] = 32'd0;
        #1 areset = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_eval_req", 32'(bus.eval_req), 32'd0);
        chk("reset_alphai", bus.alphai, 32'd0);
        chk("reset_iter", 32'(bus.iter_count), 32'd0);
        chk("reset_success", 32'(bus.success), 32'd0);
        areset = 1'b0;
        repeat (4) @(negedge aclk);

        chk("model_half", m_fmul(FLOAT_ONE, FLOAT_HALF), 32'h3F00_0000);
        chk("model_quarter", m_fmul(32'h3F00_0000, FLOAT_HALF), 32'h3E80_0000);
        chk("model_nine", m_fmul(32'h4040_0000, 32'h4040_0000), 32'h4110_0000);
        chk("model_flush", m_fmul(32'h0080_0000, FLOAT_HALF), 32'h0000_0000);

        set_plan(1'b1, 1'b1, 1'b1, 1'b1);
        run_search(FLOAT_ONE, FLOAT_HALF, 1'b0, 1'b0);
        chk("s1_latency_model", 32'(m_lat), 32'd4);
        chk("s1_success", 32'(bus.success), 32'd1);
        chk("s1_alpha_out", bus.alpha_out, 32'h3F80_0000);
        chk("s1_iter", 32'(bus.iter_count), 32'd1);

        set_plan(1'b0, 1'b0, 1'b1, 1'b1);
        run_search(FLOAT_ONE, FLOAT_HALF, 1'b0, 1'b0);
        chk("s2_latency_model", 32'(m_lat), 32'd12);
        chk("s2_alpha_out", bus.alpha_out, 32'h3E80_0000);
        chk("s2_iter", 32'(bus.iter_count), 32'd3);

        set_plan(1'b0, 1'b0, 1'b0, 1'b0);
        run_search(FLOAT_ONE, FLOAT_HALF, 1'b0, 1'b0);
        chk("s3_success", 32'(bus.success), 32'd0);
        chk("s3_alpha_out", bus.alpha_out, 32'h3E00_0000);
        chk("s3_iter", 32'(bus.iter_count), 32'd4);

        set_plan(1'b0, 1'b0, 1'b0, 1'b0);
        run_search(32'h0080_0000, FLOAT_HALF, 1'b0, 1'b0);
        chk("s4_success", 32'(bus.success), 32'd0);
        chk("s4_alpha_out", bus.alpha_out, 32'h0000_0000);
        chk("s4_iter", 32'(bus.iter_count), 32'd1);

        set_plan(1'b1, 1'b1, 1'b1, 1'b1);
        run_search(FLOAT_ONE, FLOAT_HALF, 1'b0, 1'b1);
        run_search(FLOAT_ONE, FLOAT_HALF, 1'b0, 1'b0);
        chk("s5_alpha_out", bus.alpha_out, 32'h3F80_0000);

        run_search(FLOAT_ONE, FLOAT_HALF, 1'b1, 1'b0);
        chk("s6_alpha_out", bus.alpha_out, 32'h3F80_0000);
        chk("s6_iter", 32'(bus.iter_count), 32'd1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                a0 = {1'b0, 8'($urandom_range(1, 5)), 23'($urandom)};
            else
                a0 = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
            t0 = {1'b0, 8'($urandom_range(122, 126)), 23'($urandom)};
            for (int i = 0; i < MAXI; i++) begin
                verd_a[i] = ($urandom_range(0, 2) == 0);
                dly_a[i]  = int'($urandom_range(0, 3));
            end
            run_search(a0, t0, 1'b0, 1'b0);
        end

        repeat (3) @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
